// File: rtl/sd_pkg.sv
// Shared definitions for the SD command-line path.
// Frame layout constants, the CRC7 polynomial and its serial step function,
// and the transmitter state encoding.
package sd_pkg;

  localparam int unsigned FRAME_LEN = 48;
  localparam int unsigned HDR_LEN   = 40;
  localparam int unsigned CRC_LEN   = 7;

  localparam logic [6:0] CRC7_POLY = 7'h09;  // x^7 + x^3 + 1

  localparam logic START_BIT = 1'b0;
  localparam logic TX_BIT    = 1'b1;  // host to card
  localparam logic END_BIT   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_CRC,
    ST_ENDB,
    ST_PAD,
    ST_DONE
  } tx_state_t;

  // One serial CRC7 step, MSB-first feedback.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic d);
    logic fb;
    fb = crc[6] ^ d;
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1) accumulator.
// Ports:
//   iclk  - clock, rising edge
//   irst  - asynchronous active-high reset, clears the register
//   iclr  - restart from zero; if ien is also set, the bit is folded into
//           the fresh zero state in the same cycle
//   ien   - fold idata into the CRC this cycle
//   idata - serial data bit
//   ocrc  - current CRC register
module sd_crc7
  import sd_pkg::*;
(
  input  logic       iclk,
  input  logic       irst,
  input  logic       iclr,
  input  logic       ien,
  input  logic       idata,
  output logic [6:0] ocrc
);

  logic [6:0] base;

  always_comb begin
    base = iclr ? 7'h00 : ocrc;
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      ocrc <= '0;
    end else if (iclr || ien) begin
      ocrc <= ien ? crc7_step(base, idata) : base;
    end
  end

endmodule

// File: rtl/sd_cmd_tx.sv
// SD host command-line transmitter: serialises one 48-bit command frame
// (start, transmission bit, index, argument, CRC7, end bit) MSB first,
// optionally followed by IDLE_BITS driven '1' bits before releasing CMD.
// Ports:
//   iclk       - SD clock, rising edge
//   irst       - asynchronous active-high reset; aborts any frame
//   istart     - single-cycle request, accepted only when not busy
//   icmd_index - 6-bit command index, captured on accept
//   icmd_arg   - 32-bit argument, captured on accept
//   ocmd       - serial CMD data
//   ocmd_oe    - CMD pad output enable (1 = host drives)
//   obusy      - frame in progress
//   odone      - one-cycle pulse once the frame and pad bits are out
module sd_cmd_tx
  import sd_pkg::*;
#(
  parameter int unsigned IDLE_BITS = 0
) (
  input  logic        iclk,
  input  logic        irst,
  input  logic        istart,
  input  logic [5:0]  icmd_index,
  input  logic [31:0] icmd_arg,
  output logic        ocmd,
  output logic        ocmd_oe,
  output logic        obusy,
  output logic        odone
);

  tx_state_t   state;
  logic [5:0]  cnt;
  logic [3:0]  pcnt;
  logic [39:0] sr;
  logic [39:0] hdr;
  logic [6:0]  crc;
  logic        accept;
  logic        crc_clr;
  logic        crc_en;
  logic        crc_din;

  always_comb begin
    hdr    = {START_BIT, TX_BIT, icmd_index, icmd_arg};
    accept = istart && (state == ST_IDLE || state == ST_DONE);
  end

  // The CRC is fed the bit being loaded onto ocmd at each edge, so the
  // full CRC is already registered on the edge that starts the CRC field.
  // The accept edge clears and folds in the start bit together.
  always_comb begin
    crc_clr = accept;
    crc_en  = accept || (state == ST_HDR && cnt != 6'(HDR_LEN - 1));
    crc_din = accept ? hdr[39] : sr[39];
  end

  sd_crc7 u_crc (
    .iclk  (iclk),
    .irst  (irst),
    .iclr  (crc_clr),
    .ien   (crc_en),
    .idata (crc_din),
    .ocrc  (crc)
  );

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pcnt    <= '0;
      sr      <= '0;
      ocmd    <= 1'b1;
      ocmd_oe <= 1'b0;
      obusy   <= 1'b0;
      odone   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            state   <= ST_HDR;
            cnt     <= '0;
            sr      <= {hdr[38:0], 1'b0};
            ocmd    <= hdr[39];
            ocmd_oe <= 1'b1;
            obusy   <= 1'b1;
            odone   <= 1'b0;
          end else begin
            state   <= ST_IDLE;
            ocmd    <= 1'b1;
            ocmd_oe <= 1'b0;
            obusy   <= 1'b0;
            odone   <= 1'b0;
          end
        end

        ST_HDR: begin
          if (cnt == 6'(HDR_LEN - 1)) begin
            state <= ST_CRC;
            cnt   <= '0;
            ocmd  <= crc[6];
            sr    <= {crc[5:0], 34'b0};
          end else begin
            cnt  <= cnt + 6'd1;
            ocmd <= sr[39];
            sr   <= {sr[38:0], 1'b0};
          end
        end

        ST_CRC: begin
          if (cnt == 6'(CRC_LEN - 1)) begin
            state <= ST_ENDB;
            cnt   <= '0;
            ocmd  <= END_BIT;
          end else begin
            cnt  <= cnt + 6'd1;
            ocmd <= sr[39];
            sr   <= {sr[38:0], 1'b0};
          end
        end

        ST_ENDB: begin
          ocmd <= 1'b1;
          pcnt <= '0;
          if (IDLE_BITS == 0) begin
            state   <= ST_DONE;
            ocmd_oe <= 1'b0;
            obusy   <= 1'b0;
            odone   <= 1'b1;
          end else begin
            state <= ST_PAD;
          end
        end

        ST_PAD: begin
          ocmd <= 1'b1;
          if (pcnt == 4'(IDLE_BITS - 1)) begin
            state   <= ST_DONE;
            pcnt    <= '0;
            ocmd_oe <= 1'b0;
            obusy   <= 1'b0;
            odone   <= 1'b1;
          end else begin
            pcnt <= pcnt + 4'd1;
          end
        end

        default: begin
          state   <= ST_IDLE;
          ocmd    <= 1'b1;
          ocmd_oe <= 1'b0;
          obusy   <= 1'b0;
          odone   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_tx.sv
module tb_sd_cmd_tx;

  logic        clk;
  logic        rst;
  logic        st0;
  logic        st2;
  logic [5:0]  idx;
  logic [31:0] arg;
  logic        c0, oe0, b0, d0;
  logic        c2, oe2, b2, d2;

  int nvec;
  int nerr;

  sd_cmd_tx #(.IDLE_BITS(0)) u_dut0 (
    .iclk(clk), .irst(rst), .istart(st0), .icmd_index(idx), .icmd_arg(arg),
    .ocmd(c0), .ocmd_oe(oe0), .obusy(b0), .odone(d0)
  );

  sd_cmd_tx #(.IDLE_BITS(2)) u_dut2 (
    .iclk(clk), .irst(rst), .istart(st2), .icmd_index(idx), .icmd_arg(arg),
    .ocmd(c2), .ocmd_oe(oe2), .obusy(b2), .odone(d2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [47:0] frame;
    string       nm;
  } vec_t;

  vec_t tbl[3];

  // {ocmd, ocmd_oe, obusy, odone}
  function automatic logic [3:0] flags(input int sel);
    return (sel == 0) ? {c0, oe0, b0, d0} : {c2, oe2, b2, d2};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Pulse istart so it is sampled at the next edge N; returns at cycle N+1.
  // Inputs are scrambled afterwards to prove they were captured.
  task automatic start(input int sel, input logic [5:0] i, input logic [31:0] a);
    idx = i;
    arg = a;
    if (sel == 0) st0 = 1'b1; else st2 = 1'b1;
    @(posedge clk); #1;
    st0 = 1'b0;
    st2 = 1'b0;
    idx = 6'h3F;
    arg = 32'hFFFF_FFFF;
  endtask

  // Called at cycle N+1; observes frame and pad bits, ends in the DONE cycle.
  // poke > 0 pulses istart (index 5) so it is sampled at edge N+poke.
  task automatic capture(input int sel, input int pad, input int poke,
                         input logic [47:0] exp, input string nm);
    logic [47:0] fr;
    logic [63:0] oem, bsy, padl, mask;
    logic [3:0]  f;
    int          dn;
    fr = '0; oem = '0; bsy = '0; padl = '0; dn = 0;
    for (int k = 0; k < 48 + pad; k++) begin
      f = flags(sel);
      if (k < 48) fr = {fr[46:0], f[3]};
      else padl = {padl[62:0], f[3]};
      oem = {oem[62:0], f[2]};
      bsy = {bsy[62:0], f[1]};
      dn += int'(f[0]);
      if (k == poke - 1) begin
        idx = 6'd5;
        arg = 32'hDEAD_BEEF;
        if (sel == 0) st0 = 1'b1; else st2 = 1'b1;
      end else begin
        st0 = 1'b0;
        st2 = 1'b0;
      end
      @(posedge clk); #1;
    end
    st0 = 1'b0;
    st2 = 1'b0;
    mask = (64'd1 << (48 + pad)) - 64'd1;
    chk({nm, " frame"}, 64'(fr), 64'(exp));
    chk({nm, " oe during frame"}, oem, mask);
    chk({nm, " busy during frame"}, bsy, mask);
    chk({nm, " no early done"}, 64'(dn), 64'd0);
    if (pad > 0) chk({nm, " pad bits"}, padl, (64'd1 << pad) - 64'd1);
    chk({nm, " done cycle flags"}, 64'(flags(sel)), 64'(4'b1001));
  endtask

  initial begin
    int dn;
    nvec = 0;
    nerr = 0;
    rst = 1'b1;
    st0 = 1'b0;
    st2 = 1'b0;
    idx = '0;
    arg = '0;

    tbl[0] = '{6'd0,  32'h0000_0000, 48'h40_00000000_95, "CMD0"};
    tbl[1] = '{6'd8,  32'h0000_01AA, 48'h48_000001AA_87, "CMD8"};
    tbl[2] = '{6'd17, 32'h0000_0000, 48'h51_00000000_55, "CMD17"};

    #3;
    chk("reset flags dut0", 64'(flags(0)), 64'(4'b1000));
    chk("reset flags dut2", 64'(flags(2)), 64'(4'b1000));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle after reset", 64'(flags(0)), 64'(4'b1000));

    for (int v = 0; v < 3; v++) begin
      start(0, tbl[v].idx, tbl[v].arg);
      capture(0, 0, -1, tbl[v].frame, tbl[v].nm);
      @(posedge clk); #1;
      chk({tbl[v].nm, " idle after done"}, 64'(flags(0)), 64'(4'b1000));
    end

    // istart during a frame is ignored
    start(0, 6'd8, 32'h0000_01AA);
    capture(0, 0, 10, 48'h48_000001AA_87, "CMD8 poke");
    dn = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      dn += int'(d0);
    end
    chk("poke no second done", 64'(dn), 64'd0);
    chk("poke idle", 64'(flags(0)), 64'(4'b1000));

    // back-to-back: start accepted in the DONE cycle
    start(0, 6'd0, 32'h0);
    capture(0, 0, -1, 48'h40_00000000_95, "CMD0 first");
    idx = 6'd0;
    arg = 32'h0;
    st0 = 1'b1;
    @(posedge clk); #1;
    st0 = 1'b0;
    chk("b2b start bit no gap", 64'(flags(0)), 64'(4'b0110));
    capture(0, 0, -1, 48'h40_00000000_95, "CMD0 b2b");
    @(posedge clk); #1;

    // idle bits after end bit
    start(2, 6'd0, 32'h0);
    capture(2, 2, -1, 48'h40_00000000_95, "CMD0 pad2");
    @(posedge clk); #1;
    chk("pad2 idle after done", 64'(flags(2)), 64'(4'b1000));

    // reset mid-frame
    start(0, 6'd17, 32'h0);
    repeat (19) @(posedge clk);
    #1;
    chk("midframe busy before reset", 64'(flags(0)), 64'(4'b0110) & 64'(4'b0110) | 64'(c0) << 3);
    rst = 1'b1;
    #1;
    chk("midframe reset flags", 64'(flags(0)), 64'(4'b1000));
    @(posedge clk); #1;
    rst = 1'b0;
    dn = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      dn += int'(d0);
    end
    chk("no done after abort", 64'(dn), 64'd0);
    start(0, 6'd8, 32'h0000_01AA);
    capture(0, 0, -1, 48'h48_000001AA_87, "CMD8 after reset");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
